// File: rtl/sc_regbank_btnctrl_pkg.sv
// Shared definitions for the button-controlled register bank.
// Covers the one-shot state encoding, write-mode codes and reset/button levels.
package sc_regbank_btnctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } btnState_t;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/sc_regbank_btnctrl_if.sv
// Button, operand and read-back signals of the register bank.
// The master drives the buttons and operands; the slave is the bank itself.
interface sc_regbank_btnctrl_if #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int SEL_WIDTH     = 2
);
  logic                     SC_REGBANK_clear_InLow;
  logic                     SC_REGBANK_load_InLow;
  logic [1:0]               SC_REGBANK_mode_In;
  logic [SEL_WIDTH-1:0]     SC_REGBANK_wrsel_In;
  logic [SEL_WIDTH-1:0]     SC_REGBANK_rdsel_In;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data_InBUS;
  logic [DATAWIDTH_BUS-1:0] SC_REGBANK_data_OutBUS;
  logic                     SC_REGBANK_done_Out;
  logic                     SC_REGBANK_carry_Out;
  logic                     SC_REGBANK_selerr_Out;

  modport master (
    output SC_REGBANK_clear_InLow, SC_REGBANK_load_InLow, SC_REGBANK_mode_In,
           SC_REGBANK_wrsel_In, SC_REGBANK_rdsel_In, SC_REGBANK_data_InBUS,
    input  SC_REGBANK_data_OutBUS, SC_REGBANK_done_Out, SC_REGBANK_carry_Out,
           SC_REGBANK_selerr_Out
  );

  modport slave (
    input  SC_REGBANK_clear_InLow, SC_REGBANK_load_InLow, SC_REGBANK_mode_In,
           SC_REGBANK_wrsel_In, SC_REGBANK_rdsel_In, SC_REGBANK_data_InBUS,
    output SC_REGBANK_data_OutBUS, SC_REGBANK_done_Out, SC_REGBANK_carry_Out,
           SC_REGBANK_selerr_Out
  );
endinterface

// File: rtl/sc_button_oneshot.sv
// Synchronise, debounce and one-shot a raw active-low push button.
// Emits a single-cycle pulse per accepted press.
module sc_button_oneshot
  import sc_regbank_btnctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic resetInLow,
  input  logic btnInLow,
  output logic pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0, sync_p1, level, armed;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       flushCnt;
  btnState_t        state, stateNext;

  // A button held through reset must be seen released before it may fire again;
  // the synchroniser is flushed first so its reset value cannot arm it.
  always_ff @(posedge clk) begin
    if (resetInLow == RESET_ACTIVE) begin
      sync_p0  <= BTN_RELEASED;
      sync_p1  <= BTN_RELEASED;
      level    <= BTN_RELEASED;
      cnt      <= '0;
      flushCnt <= '0;
      armed    <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      sync_p0 <= btnInLow;
      sync_p1 <= sync_p0;
      if (flushCnt != 2'd2) flushCnt <= flushCnt + 2'd1;
      if (flushCnt == 2'd2 && sync_p1 == BTN_RELEASED && level == BTN_RELEASED) armed <= 1'b1;
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    pulse     = 1'b0;
    unique case (state)
      ST_IDLE: if (level == BTN_PRESSED && armed) stateNext = ST_FIRE;
      ST_FIRE: begin
        pulse     = 1'b1;
        stateNext = ST_HOLD;
      end
      ST_HOLD: if (level == BTN_RELEASED) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/sc_regbank_btnctrl.sv
// Multi-channel register bank written by debounced clear/load buttons.
// Each accepted press performs one clear, load, add, shift or hold on the selected channel.
module sc_regbank_btnctrl
  import sc_regbank_btnctrl_pkg::*;
#(
  parameter int DATAWIDTH_BUS   = 8,
  parameter int CHANNELS        = 4,
  parameter int SEL_WIDTH       = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic             SC_REGBANK_CLOCK_50,
  input logic             SC_REGBANK_RESET_InLow,
  sc_regbank_btnctrl_if.slave bus
);
  function automatic logic [DATAWIDTH_BUS:0] addWrap(input logic [DATAWIDTH_BUS-1:0] a,
                                                     input logic [DATAWIDTH_BUS-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [DATAWIDTH_BUS-1:0] regBank [CHANNELS];
  logic                     clrPulse, ldPulse, wrEn, selOk;
  logic [DATAWIDTH_BUS-1:0] wrCur, rdData;
  logic [DATAWIDTH_BUS:0]   addSum;
  mode_t                    wrMode;

  sc_button_oneshot #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uClear (
    .clk       (SC_REGBANK_CLOCK_50),
    .resetInLow(SC_REGBANK_RESET_InLow),
    .btnInLow  (bus.SC_REGBANK_clear_InLow),
    .pulse     (clrPulse)
  );

  sc_button_oneshot #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLoad (
    .clk       (SC_REGBANK_CLOCK_50),
    .resetInLow(SC_REGBANK_RESET_InLow),
    .btnInLow  (bus.SC_REGBANK_load_InLow),
    .pulse     (ldPulse)
  );

  // Unselected or out-of-range channels read back as zero.
  always_comb begin
    wrEn   = clrPulse | ldPulse;
    selOk  = int'(bus.SC_REGBANK_wrsel_In) < CHANNELS;
    wrMode = mode_t'(bus.SC_REGBANK_mode_In);
    wrCur  = '0;
    rdData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.SC_REGBANK_wrsel_In == SEL_WIDTH'(c)) wrCur = regBank[c];
      if (bus.SC_REGBANK_rdsel_In == SEL_WIDTH'(c)) rdData = regBank[c];
    end
    addSum = addWrap(wrCur, bus.SC_REGBANK_data_InBUS);
  end

  // Write stage: clear has priority over load when both pulses coincide.
  always_ff @(posedge SC_REGBANK_CLOCK_50) begin
    if (SC_REGBANK_RESET_InLow == RESET_ACTIVE) begin
      for (int c = 0; c < CHANNELS; c++) regBank[c] <= '0;
      bus.SC_REGBANK_data_OutBUS <= '0;
      bus.SC_REGBANK_done_Out    <= 1'b0;
      bus.SC_REGBANK_carry_Out   <= 1'b0;
      bus.SC_REGBANK_selerr_Out  <= 1'b0;
    end else begin
      bus.SC_REGBANK_done_Out   <= wrEn && selOk;
      bus.SC_REGBANK_selerr_Out <= wrEn && !selOk;
      if (wrEn && selOk)
        bus.SC_REGBANK_carry_Out <= !clrPulse && wrMode == MODE_ADD && addSum[DATAWIDTH_BUS];
      for (int c = 0; c < CHANNELS; c++) begin
        if (wrEn && selOk && bus.SC_REGBANK_wrsel_In == SEL_WIDTH'(c)) begin
          if (clrPulse) begin
            regBank[c] <= '0;
          end else begin
            unique case (wrMode)
              MODE_LOAD: regBank[c] <= bus.SC_REGBANK_data_InBUS;
              MODE_ADD:  regBank[c] <= addSum[DATAWIDTH_BUS-1:0];
              MODE_SHL:  regBank[c] <= {regBank[c][DATAWIDTH_BUS-2:0], bus.SC_REGBANK_data_InBUS[0]};
              MODE_HOLD: ;
            endcase
          end
        end
      end
      bus.SC_REGBANK_data_OutBUS <= rdData;
    end
  end
endmodule

// File: tb/tb_sc_regbank_btnctrl.sv
// Directed bench for sc_regbank_btnctrl: vector table plus hand-written bounce/selerr/reset sequences.
module tb_sc_regbank_btnctrl;
  import sc_regbank_btnctrl_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  sc_regbank_btnctrl_if #(.DATAWIDTH_BUS(8), .SEL_WIDTH(2)) ifA ();
  sc_regbank_btnctrl_if #(.DATAWIDTH_BUS(8), .SEL_WIDTH(2)) ifB ();

  sc_regbank_btnctrl #(.DATAWIDTH_BUS(8), .CHANNELS(4), .SEL_WIDTH(2), .DEBOUNCE_CYCLES(4)) dutA (
    .SC_REGBANK_CLOCK_50   (clk),
    .SC_REGBANK_RESET_InLow(rstN),
    .bus                   (ifA.slave)
  );

  sc_regbank_btnctrl #(.DATAWIDTH_BUS(8), .CHANNELS(3), .SEL_WIDTH(2), .DEBOUNCE_CYCLES(4)) dutB (
    .SC_REGBANK_CLOCK_50   (clk),
    .SC_REGBANK_RESET_InLow(rstN),
    .bus                   (ifB.slave)
  );

  int cmpCnt  = 0;
  int failCnt = 0;

  typedef struct {
    int         kind;   // 0 read only, 1 load, 2 clear, 3 clear+load
    logic [1:0] mode;
    logic [1:0] wsel;
    logic [7:0] data;
    logic [1:0] rsel;
    logic [7:0] expData;
    logic       expCarry;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmpCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input bit onB, input bit c, input bit l, input logic [1:0] m,
                       input logic [1:0] ws, input logic [7:0] d,
                       output int dCnt, output int dAt, output int sCnt);
    dCnt = 0; dAt = -1; sCnt = 0;
    ifA.SC_REGBANK_mode_In = m;  ifB.SC_REGBANK_mode_In = m;
    ifA.SC_REGBANK_data_InBUS = d; ifB.SC_REGBANK_data_InBUS = d;
    if (onB) begin
      ifB.SC_REGBANK_wrsel_In = ws;
      ifB.SC_REGBANK_clear_InLow = ~c;
      ifB.SC_REGBANK_load_InLow  = ~l;
    end else begin
      ifA.SC_REGBANK_wrsel_In = ws;
      ifA.SC_REGBANK_clear_InLow = ~c;
      ifA.SC_REGBANK_load_InLow  = ~l;
    end
    for (int i = 1; i <= 26; i++) begin
      if (i == 15) begin
        ifA.SC_REGBANK_clear_InLow = 1'b1; ifA.SC_REGBANK_load_InLow = 1'b1;
        ifB.SC_REGBANK_clear_InLow = 1'b1; ifB.SC_REGBANK_load_InLow = 1'b1;
      end
      tick();
      if (onB) begin
        if (ifB.SC_REGBANK_done_Out) begin dCnt++; if (dAt < 0) dAt = i; end
        if (ifB.SC_REGBANK_selerr_Out) sCnt++;
      end else begin
        if (ifA.SC_REGBANK_done_Out) begin dCnt++; if (dAt < 0) dAt = i; end
        if (ifA.SC_REGBANK_selerr_Out) sCnt++;
      end
    end
  endtask

  int dc, da, sc, bounceDone;
  int pat [12];

  initial begin
    vecs[0]  = '{1, MODE_LOAD, 2'd2, 8'hA5, 2'd2, 8'hA5, 1'b0};
    vecs[1]  = '{0, MODE_LOAD, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0};
    vecs[2]  = '{0, MODE_LOAD, 2'd0, 8'h00, 2'd3, 8'h00, 1'b0};
    vecs[3]  = '{1, MODE_LOAD, 2'd1, 8'hF0, 2'd1, 8'hF0, 1'b0};
    vecs[4]  = '{1, MODE_ADD,  2'd1, 8'h20, 2'd1, 8'h10, 1'b1};
    vecs[5]  = '{0, MODE_LOAD, 2'd0, 8'h00, 2'd1, 8'h10, 1'b1};
    vecs[6]  = '{1, MODE_ADD,  2'd1, 8'h01, 2'd1, 8'h11, 1'b0};
    vecs[7]  = '{1, MODE_LOAD, 2'd0, 8'h81, 2'd0, 8'h81, 1'b0};
    vecs[8]  = '{1, MODE_SHL,  2'd0, 8'h01, 2'd0, 8'h03, 1'b0};
    vecs[9]  = '{3, MODE_LOAD, 2'd0, 8'h55, 2'd0, 8'h00, 1'b0};
    vecs[10] = '{1, MODE_LOAD, 2'd3, 8'h3C, 2'd3, 8'h3C, 1'b0};
    vecs[11] = '{1, MODE_ADD,  2'd3, 8'hFF, 2'd3, 8'h3B, 1'b1};
    vecs[12] = '{2, MODE_ADD,  2'd3, 8'h00, 2'd3, 8'h00, 1'b0};
    vecs[13] = '{1, MODE_ADD,  2'd3, 8'hFF, 2'd3, 8'hFF, 1'b0};
    vecs[14] = '{1, MODE_ADD,  2'd3, 8'h01, 2'd3, 8'h00, 1'b1};
    vecs[15] = '{1, MODE_HOLD, 2'd3, 8'h77, 2'd3, 8'h00, 1'b0};
    vecs[16] = '{0, MODE_LOAD, 2'd0, 8'h00, 2'd2, 8'hA5, 1'b0};
    vecs[17] = '{0, MODE_LOAD, 2'd0, 8'h00, 2'd1, 8'h11, 1'b0};

    ifA.SC_REGBANK_clear_InLow = 1'b1; ifA.SC_REGBANK_load_InLow = 1'b1;
    ifA.SC_REGBANK_mode_In = 2'b00; ifA.SC_REGBANK_wrsel_In = '0;
    ifA.SC_REGBANK_rdsel_In = '0; ifA.SC_REGBANK_data_InBUS = '0;
    ifB.SC_REGBANK_clear_InLow = 1'b1; ifB.SC_REGBANK_load_InLow = 1'b1;
    ifB.SC_REGBANK_mode_In = 2'b00; ifB.SC_REGBANK_wrsel_In = '0;
    ifB.SC_REGBANK_rdsel_In = '0; ifB.SC_REGBANK_data_InBUS = '0;
    rstN = 1'b0;
    repeat (3) tick();
    check("rst dataA",   ifA.SC_REGBANK_data_OutBUS, 0);
    check("rst doneA",   ifA.SC_REGBANK_done_Out, 0);
    check("rst carryA",  ifA.SC_REGBANK_carry_Out, 0);
    check("rst selerrA", ifA.SC_REGBANK_selerr_Out, 0);
    check("rst selerrB", ifB.SC_REGBANK_selerr_Out, 0);
    rstN = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].kind != 0) begin
        press(1'b0, vecs[i].kind[1], vecs[i].kind[0], vecs[i].mode, vecs[i].wsel,
              vecs[i].data, dc, da, sc);
        check($sformatf("v%0d doneCnt", i), dc, 1);
        check($sformatf("v%0d doneAt", i), da, 8);
        check($sformatf("v%0d selerr", i), sc, 0);
      end
      ifA.SC_REGBANK_rdsel_In = vecs[i].rsel;
      tick(); tick();
      check($sformatf("v%0d data", i), ifA.SC_REGBANK_data_OutBUS, vecs[i].expData);
      check($sformatf("v%0d carry", i), ifA.SC_REGBANK_carry_Out, vecs[i].expCarry);
    end

    // Bouncy press and release around a 100-cycle hold.
    pat = '{0, 3, 1, 3, 0, 3, 1, 3, 0, 100, 1, 3};
    ifA.SC_REGBANK_mode_In = MODE_LOAD; ifA.SC_REGBANK_wrsel_In = 2'd2;
    ifA.SC_REGBANK_data_InBUS = 8'h5A;
    bounceDone = 0;
    for (int p = 0; p < 12; p += 2) begin
      ifA.SC_REGBANK_load_InLow = pat[p][0];
      for (int k = 0; k < pat[p+1]; k++) begin
        tick();
        if (ifA.SC_REGBANK_done_Out) bounceDone++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      ifA.SC_REGBANK_load_InLow = 1'b0; repeat (3) begin tick(); if (ifA.SC_REGBANK_done_Out) bounceDone++; end
      ifA.SC_REGBANK_load_InLow = 1'b1; repeat (3) begin tick(); if (ifA.SC_REGBANK_done_Out) bounceDone++; end
    end
    repeat (15) begin tick(); if (ifA.SC_REGBANK_done_Out) bounceDone++; end
    check("bounce doneCnt", bounceDone, 1);
    ifA.SC_REGBANK_rdsel_In = 2'd2;
    tick(); tick();
    check("bounce data", ifA.SC_REGBANK_data_OutBUS, 8'h5A);

    // Three-channel bank: channel 3 does not exist.
    press(1'b1, 1'b0, 1'b1, MODE_LOAD, 2'd0, 8'hF0, dc, da, sc);
    press(1'b1, 1'b0, 1'b1, MODE_ADD, 2'd0, 8'h20, dc, da, sc);
    check("B add done", dc, 1);
    check("B carry set", ifB.SC_REGBANK_carry_Out, 1);
    press(1'b1, 1'b0, 1'b1, MODE_LOAD, 2'd3, 8'hAA, dc, da, sc);
    check("B badsel done", dc, 0);
    check("B badsel selerr", sc, 1);
    check("B carry held", ifB.SC_REGBANK_carry_Out, 1);
    ifB.SC_REGBANK_rdsel_In = 2'd3;
    tick(); tick();
    check("B rd3", ifB.SC_REGBANK_data_OutBUS, 8'h00);
    ifB.SC_REGBANK_rdsel_In = 2'd0;
    tick(); tick();
    check("B rd0", ifB.SC_REGBANK_data_OutBUS, 8'h10);

    // Reset in the middle of a debounce while the button stays held.
    press(1'b0, 1'b0, 1'b1, MODE_ADD, 2'd1, 8'hFF, dc, da, sc);
    ifA.SC_REGBANK_rdsel_In = 2'd1;
    tick(); tick();
    check("pre-rst data", ifA.SC_REGBANK_data_OutBUS, 8'h10);
    check("pre-rst carry", ifA.SC_REGBANK_carry_Out, 1);
    ifA.SC_REGBANK_mode_In = MODE_LOAD; ifA.SC_REGBANK_wrsel_In = 2'd2;
    ifA.SC_REGBANK_data_InBUS = 8'h99;
    ifA.SC_REGBANK_load_InLow = 1'b0;
    repeat (4) tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    check("mid rst data", ifA.SC_REGBANK_data_OutBUS, 0);
    check("mid rst carry", ifA.SC_REGBANK_carry_Out, 0);
    check("mid rst done", ifA.SC_REGBANK_done_Out, 0);
    dc = 0;
    repeat (30) begin tick(); if (ifA.SC_REGBANK_done_Out) dc++; end
    check("held after rst done", dc, 0);
    check("held after rst ch1", ifA.SC_REGBANK_data_OutBUS, 0);
    ifA.SC_REGBANK_rdsel_In = 2'd2;
    ifA.SC_REGBANK_load_InLow = 1'b1;
    repeat (12) tick();
    check("held after rst ch2", ifA.SC_REGBANK_data_OutBUS, 0);
    press(1'b0, 1'b0, 1'b1, MODE_LOAD, 2'd2, 8'h99, dc, da, sc);
    check("re-press done", dc, 1);
    tick(); tick();
    check("re-press data", ifA.SC_REGBANK_data_OutBUS, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
    $finish;
  end
endmodule
